// File: rtl/result_unloader_pkg.sv
// Shared constants and FSM state encoding for the result unloader (and its
// loader counterpart). Widths here are the defaults used by the top level.
package result_unloader_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LANES  = 4;
    localparam int DEF_ROWS   = 4;
    localparam int DEF_TOTAL  = DEF_LANES * DEF_ROWS;
    localparam int DEF_ADDR_W = $clog2(DEF_TOTAL);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_PREFETCH = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/result_mem.sv
// Result storage: TOTAL x DATA_W register array with one synchronous write
// port and one registered read port whose register clears on reset.
module result_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array contents survive reset; only the write port updates them.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register doubles as the streamed output data register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/result_unloader.sv
// Drains the lane result FIFOs into local memory in row-major order, then
// streams the stored elements out one per accepted valid/ready beat.
module result_unloader
    import result_unloader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = $clog2(LANES * ROWS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LANES*DATA_W-1:0] lane_rdata,
    input  logic [LANES-1:0]        lane_rempty,
    output logic [LANES-1:0]        lane_rinc,
    output logic [DATA_W-1:0]       port_O,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W:0]         drain_count
);

    localparam int TOTAL  = LANES * ROWS;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;

    logic [LANE_W-1:0] cur_lane_s;
    logic [DATA_W-1:0] cur_data_s;
    logic              pop_s;
    logic              mem_we_s;
    logic              mem_re_s;
    logic [ADDR_W-1:0] mem_raddr_s;

    // Current lane and its pop strobe; rempty is used unregistered so a lane
    // that fills in the cycle it becomes current is popped immediately.
    always_comb begin
        cur_lane_s = LANE_W'(wr_ptr_q % ADDR_W'(LANES));
        cur_data_s = lane_rdata[cur_lane_s*DATA_W +: DATA_W];
        pop_s      = (state_q == ST_DRAIN) && !lane_rempty[cur_lane_s];
        lane_rinc  = '0;
        for (int l = 0; l < LANES; l++) begin
            if (cur_lane_s == LANE_W'(l)) begin
                lane_rinc[l] = pop_s;
            end else begin
                lane_rinc[l] = 1'b0;
            end
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, pointer and memory-port control.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        mem_raddr_s = rd_ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_DRAIN;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (pop_s) begin
                    mem_we_s = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    cnt_d    = cnt_q + (ADDR_W+1)'(1);
                    if (wr_ptr_q == ADDR_W'(TOTAL - 1)) begin
                        state_d = ST_PREFETCH;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_PREFETCH: begin
                mem_re_s    = 1'b1;
                mem_raddr_s = '0;
                rd_ptr_d    = '0;
                out_valid_d = 1'b1;
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (rd_ptr_q == ADDR_W'(TOTAL - 1)) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_DONE;
                    end else begin
                        // Fetch the next element now so beats run back to back.
                        mem_re_s    = 1'b1;
                        mem_raddr_s = rd_ptr_q + ADDR_W'(1);
                        rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
                        state_d     = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    result_mem #(
        .DEPTH  (TOTAL),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (cur_data_s),
        .re_i    (mem_re_s),
        .raddr_i (mem_raddr_s),
        .rdata_o (port_O)
    );

    assign out_valid   = out_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign drain_count = cnt_q;

endmodule
